ring_token_decoder: RTL
=======================

# ring_token_decoder

Receive-side companion to the one-hot rotating stage ring in the iterative FFT control path. The block samples a one-hot token that rotates one position per step. It decodes the token to a binary stage index and checks that every move is a legal single-position rotation. It also counts full ring revolutions, so the controller knows how many FFT passes have completed. It sits between the ring output and the address-generation and twiddle-selection logic.

## Interface
- BITNESS, 16, token width in bits (≥2)
- shLeft, 1, expected rotation direction: 1 = toward MSB (bit BITNESS-1 wraps to bit 0); 0 = toward LSB (bit 0 wraps to bit BITNESS-1)
- RESET_VALUE, 1, token assumed present at reset; must be one-hot
- IDX_W, 4, index width; must be ≥ ceil(log2(BITNESS))
- WRAP_W, 8, revolution counter width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  sample enable, active high
- i_CLR  in  1  synchronous clear of o_ERR and o_WRAP_CNT
- i_DATA  in  BITNESS  token from ring
- o_IDX  out  IDX_W  position of set bit (bit 0 → 0)
- o_VALID  out  1  last sampled token was one-hot
- o_STEP  out  1  one-cycle pulse: legal one-position advance
- o_WRAP  out  1  one-cycle pulse: advance crossed the wrap boundary
- o_WRAP_CNT  out  WRAP_W  completed revolutions, saturating
- o_ERR  out  1  sticky protocol error

## Operation
- Internal register PREV (BITNESS bits) holds the last accepted one-hot token. PREV resets to RESET_VALUE.
- EN=0: o_STEP=0 and o_WRAP=0. All other state holds.
- EN=1, sample i_DATA; classify:
  - not one-hot (zero or ≥2 bits set): o_VALID←0; o_IDX and PREV hold; o_ERR←1; no pulses.
  - HOLD (i_DATA==PREV): o_VALID←1; o_IDX←index; no pulses.
  - STEP (i_DATA==rot(PREV)):
    - o_VALID←1; o_IDX←index; PREV←i_DATA; o_STEP←1.
    - rot = {PREV[B-2:0],PREV[B-1]} when shLeft=1; {PREV[0],PREV[B-1:1]} when shLeft=0.
    - If PREV had its wrap bit set (bit B-1 for shLeft=1, bit 0 for shLeft=0): o_WRAP←1, and o_WRAP_CNT increments, saturating at 2^WRAP_W-1.
  - JUMP (one-hot, neither HOLD nor STEP): o_VALID←1; o_IDX←index; PREV←i_DATA (resync); o_ERR←1; no pulses.
- i_CLR=1 clears o_ERR and o_WRAP_CNT, independent of EN.
  - If a new error or wrap occurs in the same cycle, the error or wrap wins: o_ERR=1, o_WRAP_CNT=1.
- BITNESS not a power of two: o_IDX is still the bit position; the upper codes are unused.

## Timing
- All outputs are registered. Latency is 1 cycle: i_DATA sampled at edge N appears on outputs after edge N.
- o_STEP and o_WRAP are high for exactly one cycle per qualifying sample. Back-to-back STEPs give back-to-back pulses.
- Reset values: o_IDX=0, o_VALID=0, o_STEP=0, o_WRAP=0, o_WRAP_CNT=0, o_ERR=0, PREV=RESET_VALUE.
- Reset asserted mid-operation clears all state immediately, without waiting for CLK. The first sample after release is compared against RESET_VALUE.
- o_ERR stays high until i_CLR or reset.

## Test plan
- BITNESS=4, shLeft=1, RESET_VALUE=1: EN=1, i_DATA = 0001, 0010, 0100, 1000, 0001.
  - o_IDX 0,1,2,3,0.
  - o_STEP pulses on samples 2–5.
  - o_WRAP pulses on sample 5 only; o_WRAP_CNT=1; o_ERR=0.
- Same config: i_DATA=0010 held for 3 EN cycles, then EN=0 for 2 cycles.
  - Pulses only on first sample; o_IDX=1 throughout.
  - During EN=0 outputs hold and pulses are 0.
- Same config, PREV=0001: i_DATA=0110 → o_VALID=0, o_ERR=1, o_IDX unchanged. Next i_DATA=0010 → STEP pulse (PREV unchanged), o_VALID=1.
- shLeft=0, RESET_VALUE=1: i_DATA=1000 → STEP and WRAP pulse, o_WRAP_CNT=1. Then i_DATA=0010 → JUMP: o_ERR=1, o_IDX=1, no STEP.
- WRAP_W=2: drive 5 full revolutions → o_WRAP_CNT saturates at 3. Then i_CLR=1 in the same cycle as a wrap → o_WRAP_CNT=1.
- Assert RST mid-sequence (PREV=0100) without a CLK edge → outputs go to reset values immediately. After release, i_DATA=0010 → STEP from RESET_VALUE 0001.

Source files
------------

// File: rtl/ring_token_decoder_if.sv
// Token/status bundle between the stage ring and its receive-side decoder.
// master drives the sampled token, slave returns index, pulses and status.
interface ring_token_decoder_if #(
  parameter int BITNESS = 16,
  parameter int IDX_W   = 4,
  parameter int WRAP_W  = 8
);
  logic               EN;
  logic               i_CLR;
  logic [BITNESS-1:0] i_DATA;
  logic [IDX_W-1:0]   o_IDX;
  logic               o_VALID;
  logic               o_STEP;
  logic               o_WRAP;
  logic [WRAP_W-1:0]  o_WRAP_CNT;
  logic               o_ERR;

  modport master (
    output EN, i_CLR, i_DATA,
    input  o_IDX, o_VALID, o_STEP,
    input  o_WRAP, o_WRAP_CNT, o_ERR
  );

  modport slave (
    input  EN, i_CLR, i_DATA,
    output o_IDX, o_VALID, o_STEP,
    output o_WRAP, o_WRAP_CNT, o_ERR
  );
endinterface

// File: rtl/ring_token_decoder.sv
// Decodes a rotating one-hot stage token, checks each move is a single
// legal rotation and counts completed ring revolutions.
module ring_token_decoder #(
  parameter int                 BITNESS     = 16,
  parameter bit                 shLeft      = 1'b1,
  parameter logic [BITNESS-1:0] RESET_VALUE = BITNESS'(1),
  parameter int                 IDX_W       = 4,
  parameter int                 WRAP_W      = 8
) (
  input logic                CLK,
  input logic                RST,
  ring_token_decoder_if.slave bus
);

  localparam logic [WRAP_W-1:0] CNT_MAX = {WRAP_W{1'b1}};

  logic [BITNESS-1:0] prev_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic               step_q;
  logic               wrap_q;
  logic [WRAP_W-1:0]  cnt_q;
  logic               err_q;

  logic [BITNESS-1:0] data;
  logic [BITNESS-1:0] rot;
  logic [IDX_W-1:0]   idx_d;
  logic               onehot;
  logic               is_hold;
  logic               is_step;
  logic               is_jump;
  logic               wrap_bit;
  logic               wrap_ev;
  logic               err_ev;

  assign data = bus.i_DATA;

  always_comb begin
    onehot = (data != '0) &&
             ((data & (data - BITNESS'(1))) == '0);
    if (shLeft) begin
      rot      = {prev_q[BITNESS-2:0], prev_q[BITNESS-1]};
      wrap_bit = prev_q[BITNESS-1];
    end else begin
      rot      = {prev_q[0], prev_q[BITNESS-1:1]};
      wrap_bit = prev_q[0];
    end
    is_hold = onehot && (data == prev_q);
    is_step = onehot && !is_hold && (data == rot);
    is_jump = onehot && !is_hold && !is_step;
    wrap_ev = bus.EN && is_step && wrap_bit;
    err_ev  = bus.EN && (!onehot || is_jump);
  end

  always_comb begin
    idx_d = '0;
    for (int i = 0; i < BITNESS; i++) begin
      if (data[i]) idx_d = IDX_W'(i);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_q  <= RESET_VALUE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.EN) begin
        unique case (1'b1)
          !onehot: valid_q <= 1'b0;
          is_hold: begin
            valid_q <= 1'b1;
            idx_q   <= idx_d;
          end
          is_step: begin
            valid_q <= 1'b1;
            idx_q   <= idx_d;
            prev_q  <= data;
            step_q  <= 1'b1;
            wrap_q  <= wrap_bit;
          end
          is_jump: begin
            valid_q <= 1'b1;
            idx_q   <= idx_d;
            prev_q  <= data;
          end
        endcase
      end
      // a fresh error or wrap outranks a simultaneous clear
      err_q <= err_ev || (err_q && !bus.i_CLR);
      if (wrap_ev) begin
        if (bus.i_CLR)
          cnt_q <= WRAP_W'(1);
        else if (cnt_q != CNT_MAX)
          cnt_q <= cnt_q + WRAP_W'(1);
      end else if (bus.i_CLR) begin
        cnt_q <= '0;
      end
    end
  end

  assign bus.o_IDX      = idx_q;
  assign bus.o_VALID    = valid_q;
  assign bus.o_STEP     = step_q;
  assign bus.o_WRAP     = wrap_q;
  assign bus.o_WRAP_CNT = cnt_q;
  assign bus.o_ERR      = err_q;

endmodule
